// File: rtl/uart_protocal_rx_stm_if.sv
// Signal bundle between the CFG layer / UART RX core (master side) and the
// receive-side protocol state machine (slave side).
//
// Handshake: CORE_PROT_rx_valid is a one-cycle pulse that qualifies
// CORE_PROT_rx_data and CORE_PROT_rx_ferr in the same cycle. There is no
// ready back to the core. CFG_PROT_ctrl_full is the only backpressure, and
// it affects payload bytes only. PROT_CFG_ctrl_rx_w_en is a one-cycle write
// strobe that qualifies PROT_CFG_rx_wdata. The FIFO must accept the write
// whenever it reported not-full in the cycle the byte arrived.
interface uart_protocal_rx_stm_if;
    logic       CFG_PROT_ctrl_Rxen;
    logic [7:0] CFG_PROT_slave_addr;
    logic       CFG_PROT_ctrl_full;
    logic       CFG_PROT_err_clr;
    logic       CORE_PROT_rx_valid;
    logic [7:0] CORE_PROT_rx_data;
    logic       CORE_PROT_rx_ferr;
    logic       PROT_CFG_ctrl_rx_w_en;
    logic [7:0] PROT_CFG_rx_wdata;
    logic       PROT_CFG_pkt_done;
    logic       PROT_CFG_err_ovf;
    logic       PROT_CFG_err_frame;
    logic       PROT_CFG_err_tout;
    logic       PROT_USR_ctrl_rts;
    logic [1:0] PROT_CFG_rx_state;

    // Configuration and core side: drives the controls and received bytes.
    modport master (
        output CFG_PROT_ctrl_Rxen,
        output CFG_PROT_slave_addr,
        output CFG_PROT_ctrl_full,
        output CFG_PROT_err_clr,
        output CORE_PROT_rx_valid,
        output CORE_PROT_rx_data,
        output CORE_PROT_rx_ferr,
        input  PROT_CFG_ctrl_rx_w_en,
        input  PROT_CFG_rx_wdata,
        input  PROT_CFG_pkt_done,
        input  PROT_CFG_err_ovf,
        input  PROT_CFG_err_frame,
        input  PROT_CFG_err_tout,
        input  PROT_USR_ctrl_rts,
        input  PROT_CFG_rx_state
    );

    // Protocol state machine side.
    modport slave (
        input  CFG_PROT_ctrl_Rxen,
        input  CFG_PROT_slave_addr,
        input  CFG_PROT_ctrl_full,
        input  CFG_PROT_err_clr,
        input  CORE_PROT_rx_valid,
        input  CORE_PROT_rx_data,
        input  CORE_PROT_rx_ferr,
        output PROT_CFG_ctrl_rx_w_en,
        output PROT_CFG_rx_wdata,
        output PROT_CFG_pkt_done,
        output PROT_CFG_err_ovf,
        output PROT_CFG_err_frame,
        output PROT_CFG_err_tout,
        output PROT_USR_ctrl_rts,
        output PROT_CFG_rx_state
    );
endinterface

// File: rtl/uart_protocal_rx_stm.sv
// Receive-side protocol state machine.
// The incoming packet is [slave address][payload ...][STOP_CODE]. The block
// filters packets by address and writes payload bytes into the RX FIFO. It
// also detects the stop frame, generates RTS and keeps sticky overflow,
// framing and inter-byte timeout flags. Every output is registered.
module uart_protocal_rx_stm #(
    parameter logic [7:0] STOP_CODE   = 8'h0A,
    parameter logic [7:0] BCAST_ADDR  = 8'h00,
    parameter int         TIMEOUT_CYC = 4096
) (
    input  logic                  glb_clk,
    input  logic                  glb_rstn,
    uart_protocal_rx_stm_if.slave bus
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] TOUT_LIM = CNT_W'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RECV_ADDR = 2'd1,
        ST_RECV_DATA = 2'd2,
        ST_DISCARD   = 2'd3
    } rx_state_e;

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       wr_d, done_d;
    logic       ovf_set, frame_set, tout_set;
    logic       rx_en, rx_valid, rx_ferr, is_stop, addr_hit, tout_hit, in_pkt;
    logic [7:0] rx_data;

    logic       w_en_q, done_q, ovf_q, frame_q, tout_q, rts_q;
    logic [7:0] wdata_q;

    assign rx_en    = bus.CFG_PROT_ctrl_Rxen;
    assign rx_valid = bus.CORE_PROT_rx_valid;
    assign rx_data  = bus.CORE_PROT_rx_data;
    assign rx_ferr  = bus.CORE_PROT_rx_ferr;
    assign is_stop  = (rx_data == STOP_CODE);
    assign addr_hit = (rx_data == bus.CFG_PROT_slave_addr) || (rx_data == BCAST_ADDR);
    assign in_pkt   = (state_q == ST_RECV_DATA) || (state_q == ST_DISCARD);
    // The timeout only takes effect on a cycle with no byte. A byte that
    // arrives in the expiry cycle is processed normally.
    assign tout_hit = (cnt_q == TOUT_LIM) && !rx_valid;

    // State register.
    always_ff @(posedge glb_clk or negedge glb_rstn) begin
        if (!glb_rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and per-byte actions. Dropping the enable has priority over everything else.
    always_comb begin
        state_d   = state_q;
        wr_d      = 1'b0;
        done_d    = 1'b0;
        ovf_set   = 1'b0;
        frame_set = 1'b0;
        tout_set  = 1'b0;
        if (!rx_en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_RECV_ADDR;
                end
                ST_RECV_ADDR: begin
                    if (rx_valid) begin
                        if (rx_ferr) begin
                            frame_set = 1'b1;
                        end else if (addr_hit) begin
                            state_d = ST_RECV_DATA;
                        end else begin
                            state_d = ST_DISCARD;
                        end
                    end
                end
                ST_RECV_DATA: begin
                    if (rx_valid) begin
                        if (rx_ferr) begin
                            frame_set = 1'b1;
                            state_d   = ST_DISCARD;
                        end else if (is_stop) begin
                            done_d  = 1'b1;
                            state_d = ST_RECV_ADDR;
                        end else if (!bus.CFG_PROT_ctrl_full) begin
                            wr_d = 1'b1;
                        end else begin
                            ovf_set = 1'b1;
                        end
                    end else if (tout_hit) begin
                        tout_set = 1'b1;
                        state_d  = ST_RECV_ADDR;
                    end
                end
                ST_DISCARD: begin
                    if (rx_valid) begin
                        if (is_stop && !rx_ferr) begin
                            state_d = ST_RECV_ADDR;
                        end
                    end else if (tout_hit) begin
                        state_d = ST_RECV_ADDR;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Inter-byte idle counter. It runs only while inside a packet and
    // restarts on every byte and on every state change.
    always_comb begin
        if (!rx_en || rx_valid || !in_pkt || (state_d != state_q)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Idle counter register.
    always_ff @(posedge glb_clk or negedge glb_rstn) begin
        if (!glb_rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Registered outputs. For sticky flags, a set in the same cycle as a clear wins.
    always_ff @(posedge glb_clk or negedge glb_rstn) begin
        if (!glb_rstn) begin
            w_en_q  <= 1'b0;
            wdata_q <= 8'h00;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            frame_q <= 1'b0;
            tout_q  <= 1'b0;
            rts_q   <= 1'b0;
        end else begin
            w_en_q <= wr_d;
            if (wr_d) begin
                wdata_q <= rx_data;
            end
            done_q  <= done_d;
            ovf_q   <= ovf_set   | (ovf_q   & ~bus.CFG_PROT_err_clr);
            frame_q <= frame_set | (frame_q & ~bus.CFG_PROT_err_clr);
            tout_q  <= tout_set  | (tout_q  & ~bus.CFG_PROT_err_clr);
            rts_q   <= rx_en & ~bus.CFG_PROT_ctrl_full;
        end
    end

    assign bus.PROT_CFG_ctrl_rx_w_en = w_en_q;
    assign bus.PROT_CFG_rx_wdata     = wdata_q;
    assign bus.PROT_CFG_pkt_done     = done_q;
    assign bus.PROT_CFG_err_ovf      = ovf_q;
    assign bus.PROT_CFG_err_frame    = frame_q;
    assign bus.PROT_CFG_err_tout     = tout_q;
    assign bus.PROT_USR_ctrl_rts     = rts_q;
    assign bus.PROT_CFG_rx_state     = state_q;

endmodule

// File: tb/tb_uart_protocal_rx_stm.sv
// Testbench for uart_protocal_rx_stm: directed packet scenarios plus a
// randomized byte stream, all checked against a packet-level reference
// model on every cycle.
module tb_uart_protocal_rx_stm;

    localparam int          TOUT     = 4096;
    localparam logic [7:0]  STOP     = 8'h0A;
    localparam logic [7:0]  BCAST    = 8'h00;
    localparam logic [1:0]  S_IDLE   = 2'd0;
    localparam logic [1:0]  S_ADDR   = 2'd1;
    localparam logic [1:0]  S_DATA   = 2'd2;
    localparam logic [1:0]  S_DISC   = 2'd3;

    logic glb_clk;
    logic glb_rstn;

    uart_protocal_rx_stm_if bus ();

    uart_protocal_rx_stm #(
        .STOP_CODE   (STOP),
        .BCAST_ADDR  (BCAST),
        .TIMEOUT_CYC (TOUT)
    ) dut (
        .glb_clk  (glb_clk),
        .glb_rstn (glb_rstn),
        .bus      (bus)
    );

    // ---------------- clock / reset ----------------
    initial glb_clk = 1'b0;
    always #5 glb_clk = ~glb_clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no end, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- bookkeeping ----------------
    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] exp_q[$];   // payload bytes the model says must be written
    logic [7:0] wr_log[$];  // payload bytes the DUT actually wrote
    int         done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Packet-level view: where are we in the packet, how long since the last
    // byte, and which events occurred on this byte.
    typedef struct packed {
        logic [1:0] st;
        logic       wen;
        logic [7:0] wd;
        logic       done;
        logic       ovf;
        logic       frame;
        logic       tout;
        logic       rts;
        int         idle;
    } model_t;

    model_t m, m_nxt;

    function automatic model_t model_step(input model_t cur, input logic rxen, input logic full,
                                          input logic clr, input logic valid, input logic [7:0] data,
                                          input logic ferr, input logic [7:0] addr);
        model_t n;
        logic ovf_ev, frame_ev, tout_ev;
        n        = cur;
        n.wen    = 1'b0;
        n.done   = 1'b0;
        ovf_ev   = 1'b0;
        frame_ev = 1'b0;
        tout_ev  = 1'b0;
        if (!rxen) begin
            n.st = S_IDLE;
        end else if (cur.st == S_IDLE) begin
            n.st = S_ADDR;
        end else if (cur.st == S_ADDR) begin
            if (valid && ferr) frame_ev = 1'b1;
            else if (valid && (data == addr || data == BCAST)) n.st = S_DATA;
            else if (valid) n.st = S_DISC;
        end else if (cur.st == S_DATA) begin
            if (valid && ferr) begin
                frame_ev = 1'b1;
                n.st     = S_DISC;
            end else if (valid && data == STOP) begin
                n.done = 1'b1;
                n.st   = S_ADDR;
            end else if (valid && !full) begin
                n.wen = 1'b1;
                n.wd  = data;
            end else if (valid) begin
                ovf_ev = 1'b1;
            end else if (cur.idle == TOUT) begin
                tout_ev = 1'b1;
                n.st    = S_ADDR;
            end
        end else begin
            if (valid && data == STOP && !ferr) n.st = S_ADDR;
            else if (!valid && cur.idle == TOUT) n.st = S_ADDR;
        end
        // idle cycles since the last byte, counted only while inside a packet
        n.idle  = (valid || cur.st == S_IDLE || cur.st == S_ADDR) ? 0 : cur.idle + 1;
        n.ovf   = ovf_ev   | (cur.ovf   & ~clr);
        n.frame = frame_ev | (cur.frame & ~clr);
        n.tout  = tout_ev  | (cur.tout  & ~clr);
        n.rts   = rxen & ~full;
        return n;
    endfunction

    always @(posedge glb_clk or negedge glb_rstn) begin
        if (!glb_rstn) begin
            m <= '0;
            exp_q.delete();
        end else begin
            m_nxt = model_step(m, bus.CFG_PROT_ctrl_Rxen, bus.CFG_PROT_ctrl_full, bus.CFG_PROT_err_clr,
                               bus.CORE_PROT_rx_valid, bus.CORE_PROT_rx_data, bus.CORE_PROT_rx_ferr,
                               bus.CFG_PROT_slave_addr);
            if (m_nxt.wen) exp_q.push_back(m_nxt.wd);
            m <= m_nxt;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge glb_clk) begin
        check("w_en",  bus.PROT_CFG_ctrl_rx_w_en, m.wen);
        check("done",  bus.PROT_CFG_pkt_done,     m.done);
        check("ovf",   bus.PROT_CFG_err_ovf,      m.ovf);
        check("frame", bus.PROT_CFG_err_frame,    m.frame);
        check("tout",  bus.PROT_CFG_err_tout,     m.tout);
        check("rts",   bus.PROT_USR_ctrl_rts,     m.rts);
        check("state", bus.PROT_CFG_rx_state,     m.st);
        if (bus.PROT_CFG_ctrl_rx_w_en === 1'b1) begin
            wr_log.push_back(bus.PROT_CFG_rx_wdata);
            if (exp_q.size() == 0) begin
                check("wdata_unexpected", 32'(bus.PROT_CFG_rx_wdata), 32'hFFFF_FFFF);
            end else begin
                check("wdata", bus.PROT_CFG_rx_wdata, exp_q.pop_front());
            end
        end
        if (bus.PROT_CFG_pkt_done === 1'b1) done_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge glb_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic fe = 1'b0);
        bus.CORE_PROT_rx_valid = 1'b1;
        bus.CORE_PROT_rx_data  = d;
        bus.CORE_PROT_rx_ferr  = fe;
        tick();
        bus.CORE_PROT_rx_valid = 1'b0;
        bus.CORE_PROT_rx_ferr  = 1'b0;
    endtask

    task automatic clr_pulse();
        bus.CFG_PROT_err_clr = 1'b1;
        tick();
        bus.CFG_PROT_err_clr = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    int n_wr, n_done;

    initial begin
        glb_rstn                = 1'b0;
        bus.CFG_PROT_ctrl_Rxen  = 1'b0;
        bus.CFG_PROT_slave_addr = 8'h42;
        bus.CFG_PROT_ctrl_full  = 1'b0;
        bus.CFG_PROT_err_clr    = 1'b0;
        bus.CORE_PROT_rx_valid  = 1'b0;
        bus.CORE_PROT_rx_data   = 8'h00;
        bus.CORE_PROT_rx_ferr   = 1'b0;
        repeat (3) tick();
        glb_rstn = 1'b1;
        tick();
        check("reset_state", bus.PROT_CFG_rx_state, S_IDLE);
        check("reset_rts",   bus.PROT_USR_ctrl_rts, 1'b0);
        check("reset_w_en",  bus.PROT_CFG_ctrl_rx_w_en, 1'b0);

        // 1: addressed packet, two payload bytes
        bus.CFG_PROT_ctrl_Rxen = 1'b1;
        tick();
        check("t1_state_addr", bus.PROT_CFG_rx_state, S_ADDR);
        check("t1_rts", bus.PROT_USR_ctrl_rts, 1'b1);
        n_wr = wr_log.size(); n_done = done_cnt;
        send_byte(8'h42);
        check("t1_state_data", bus.PROT_CFG_rx_state, S_DATA);
        send_byte(8'h11);
        check("t1_w_en_11", {bus.PROT_CFG_ctrl_rx_w_en, bus.PROT_CFG_rx_wdata}, {1'b1, 8'h11});
        send_byte(8'h22);
        check("t1_w_en_22", {bus.PROT_CFG_ctrl_rx_w_en, bus.PROT_CFG_rx_wdata}, {1'b1, 8'h22});
        send_byte(8'h0A);
        check("t1_done", {bus.PROT_CFG_pkt_done, bus.PROT_CFG_ctrl_rx_w_en}, 2'b10);
        tick();
        check("t1_nwrites", wr_log.size() - n_wr, 2);
        check("t1_ndone", done_cnt - n_done, 1);
        check("t1_state_end", bus.PROT_CFG_rx_state, S_ADDR);

        // 2: foreign address is discarded, broadcast address is accepted
        n_wr = wr_log.size(); n_done = done_cnt;
        send_byte(8'h55);
        check("t2_state_disc", bus.PROT_CFG_rx_state, S_DISC);
        send_byte(8'h11);
        send_byte(8'h0A);
        check("t2_state_back", bus.PROT_CFG_rx_state, S_ADDR);
        check("t2_nwrites", wr_log.size() - n_wr, 0);
        check("t2_ndone", done_cnt - n_done, 0);
        send_byte(8'h00);
        send_byte(8'h11);
        check("t2_bcast_w", {bus.PROT_CFG_ctrl_rx_w_en, bus.PROT_CFG_rx_wdata}, {1'b1, 8'h11});
        send_byte(8'h0A);

        // 3: overflow while the FIFO is full; clear; set coinciding with clear
        bus.CFG_PROT_ctrl_full = 1'b1;
        send_byte(8'h42);
        check("t3_rts_full", bus.PROT_USR_ctrl_rts, 1'b0);
        send_byte(8'h33);
        check("t3_no_w", bus.PROT_CFG_ctrl_rx_w_en, 1'b0);
        check("t3_ovf", bus.PROT_CFG_err_ovf, 1'b1);
        clr_pulse();
        check("t3_ovf_clr", bus.PROT_CFG_err_ovf, 1'b0);
        bus.CFG_PROT_err_clr = 1'b1;
        send_byte(8'h44);
        bus.CFG_PROT_err_clr = 1'b0;
        check("t3_set_wins", bus.PROT_CFG_err_ovf, 1'b1);
        bus.CFG_PROT_ctrl_full = 1'b0;
        send_byte(8'h0A);
        check("t3_done", bus.PROT_CFG_pkt_done, 1'b1);
        clr_pulse();

        // 4: inter-byte timeout, then a byte landing exactly on the expiry cycle
        n_done = done_cnt;
        send_byte(8'h42);
        send_byte(8'h11);
        repeat (TOUT) tick();
        check("t4_pre_state", bus.PROT_CFG_rx_state, S_DATA);
        check("t4_pre_tout", bus.PROT_CFG_err_tout, 1'b0);
        tick();
        check("t4_state", bus.PROT_CFG_rx_state, S_ADDR);
        check("t4_tout", bus.PROT_CFG_err_tout, 1'b1);
        check("t4_ndone", done_cnt - n_done, 0);
        clr_pulse();
        send_byte(8'h42);
        send_byte(8'h11);
        repeat (TOUT) tick();
        send_byte(8'h22);
        check("t4_edge_w", {bus.PROT_CFG_ctrl_rx_w_en, bus.PROT_CFG_rx_wdata}, {1'b1, 8'h22});
        check("t4_edge_state", bus.PROT_CFG_rx_state, S_DATA);
        check("t4_edge_tout", bus.PROT_CFG_err_tout, 1'b0);
        send_byte(8'h0A);

        // 5: framing error on a payload byte
        send_byte(8'h42);
        send_byte(8'h11);
        send_byte(8'h55, 1'b1);
        check("t5_frame", bus.PROT_CFG_err_frame, 1'b1);
        check("t5_state", bus.PROT_CFG_rx_state, S_DISC);
        check("t5_no_w", bus.PROT_CFG_ctrl_rx_w_en, 1'b0);
        send_byte(8'h0A);
        check("t5_back", bus.PROT_CFG_rx_state, S_ADDR);
        clr_pulse();

        // 6: enable dropped mid-packet; async reset mid-packet
        send_byte(8'h42);
        send_byte(8'h11);
        bus.CFG_PROT_ctrl_Rxen = 1'b0;
        tick();
        check("t6_idle", bus.PROT_CFG_rx_state, S_IDLE);
        check("t6_rts", bus.PROT_USR_ctrl_rts, 1'b0);
        bus.CFG_PROT_ctrl_Rxen = 1'b1;
        tick();
        send_byte(8'h42);
        bus.CFG_PROT_ctrl_full = 1'b1;
        send_byte(8'h11);
        bus.CFG_PROT_ctrl_full = 1'b0;
        send_byte(8'h12, 1'b1);
        send_byte(8'h42);
        send_byte(8'h13);
        glb_rstn = 1'b0;
        #1;
        check("t6_rst_outs",
              {bus.PROT_CFG_ctrl_rx_w_en, bus.PROT_CFG_rx_wdata, bus.PROT_CFG_pkt_done,
               bus.PROT_CFG_err_ovf, bus.PROT_CFG_err_frame, bus.PROT_CFG_err_tout,
               bus.PROT_USR_ctrl_rts, bus.PROT_CFG_rx_state}, 32'h0);
        repeat (2) tick();
        glb_rstn = 1'b1;
        tick();

        // randomized byte stream against the model
        for (int i = 0; i < 3000; i++) begin
            bus.CFG_PROT_ctrl_Rxen = ($urandom_range(0, 99) != 0);
            bus.CFG_PROT_ctrl_full = ($urandom_range(0, 9) < 2);
            bus.CFG_PROT_err_clr   = ($urandom_range(0, 19) == 0);
            bus.CORE_PROT_rx_valid = ($urandom_range(0, 2) == 0);
            bus.CORE_PROT_rx_ferr  = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 4))
                0:       bus.CORE_PROT_rx_data = 8'h42;
                1:       bus.CORE_PROT_rx_data = 8'h00;
                2:       bus.CORE_PROT_rx_data = 8'h0A;
                default: bus.CORE_PROT_rx_data = 8'($urandom_range(0, 255));
            endcase
            tick();
        end
        bus.CORE_PROT_rx_valid = 1'b0;
        bus.CORE_PROT_rx_ferr  = 1'b0;
        bus.CFG_PROT_err_clr   = 1'b0;
        repeat (3) tick();
        check("exp_q_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
